vidmem_arbiter: RTL and testbench

- Shares the single video-memory bus between two requesters: the framebuffer scanline fetcher (read-only, 24-bit pixel reads) and the CPU (read/write).
- Sits between the framebuffer's bus_read/bus_wait/address/data interface, the CPU's memory-mapped port, and the SRAM/SDRAM controller.
- Video has priority so the line buffer fills before active display.
- One transaction per grant; one idle cycle between transactions.

---
 rtl/vidmem_arb_pkg.sv | 24 ++
 rtl/vidmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_vidmem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vidmem_arb_pkg.sv
// Shared encodings for the video-memory arbiter: FSM states, bus owner tags
// and the width of a pixel word.
package vidmem_arb_pkg;

    localparam int VIDEO_DATA_W = 24;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GNT_VID = 2'd1;
    localparam logic [1:0] ST_GNT_CPU = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    // A simultaneous read+write CPU request is carried out as a write.
    function automatic logic cpu_rd_only(input logic rd, input logic wr);
        return rd & ~wr;
    endfunction

endpackage

// File: rtl/vidmem_arbiter.sv
// Two-master arbiter for the video memory bus: scanline fetcher (priority) and CPU.
// Build with VIDMEM_ARB_FAIRNESS_EN to bound consecutive video grants while the CPU waits.
module vidmem_arbiter
    import vidmem_arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_VID_BURST = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,

    input  logic                    i_vid_read,
    input  logic [ADDR_W-1:0]       i_vid_address,
    output logic                    o_vid_wait,
    output logic [VIDEO_DATA_W-1:0] o_vid_data,

    input  logic                    i_cpu_read,
    input  logic                    i_cpu_write,
    input  logic [ADDR_W-1:0]       i_cpu_address,
    input  logic [DATA_W-1:0]       i_cpu_wdata,
    input  logic [DATA_W/8-1:0]     i_cpu_be,
    output logic                    o_cpu_wait,
    output logic [DATA_W-1:0]       o_cpu_rdata,

    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic [ADDR_W-1:0]       o_mem_address,
    output logic [DATA_W-1:0]       o_mem_wdata,
    output logic [DATA_W/8-1:0]     o_mem_be,
    input  logic                    i_mem_wait,
    input  logic [DATA_W-1:0]       i_mem_rdata
);

    logic [1:0]              r_state;
    owner_e                  r_owner;
    logic                    r_mem_read;
    logic                    r_mem_write;
    logic [ADDR_W-1:0]       r_mem_address;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic [DATA_W/8-1:0]     r_mem_be;
    logic [VIDEO_DATA_W-1:0] r_vid_data;
    logic [DATA_W-1:0]       r_cpu_rdata;

    logic w_cpu_req;
    logic w_pick_vid;
    logic w_pick_cpu;

    assign w_cpu_req = i_cpu_read | i_cpu_write;

`ifdef VIDMEM_ARB_FAIRNESS_EN
    localparam int FAIR_W = $clog2(MAX_VID_BURST + 1);

    logic [FAIR_W-1:0] r_fair_cnt;
    logic              w_fair_force;

    assign w_fair_force = (r_fair_cnt == FAIR_W'(MAX_VID_BURST));
    assign w_pick_cpu   = w_cpu_req & (~i_vid_read | w_fair_force);

    // Counts video grants that jumped ahead of a waiting CPU request.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_fair_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (!w_cpu_req || w_pick_cpu)
                r_fair_cnt <= '0;
            else if (w_pick_vid)
                r_fair_cnt <= r_fair_cnt + 1'b1;
        end
    end
`else
    assign w_pick_cpu = w_cpu_req & ~i_vid_read;
`endif

    assign w_pick_vid = i_vid_read & ~w_pick_cpu;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_NONE;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_be      <= '0;
            r_vid_data    <= '0;
            r_cpu_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vid) begin
                        r_state       <= ST_GNT_VID;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= i_vid_address;
                        r_mem_wdata   <= '0;
                        r_mem_be      <= '1;
                    end else if (w_pick_cpu) begin
                        r_state       <= ST_GNT_CPU;
                        r_mem_read    <= cpu_rd_only(i_cpu_read, i_cpu_write);
                        r_mem_write   <= i_cpu_write;
                        r_mem_address <= i_cpu_address;
                        r_mem_wdata   <= i_cpu_wdata;
                        r_mem_be      <= i_cpu_be;
                    end
                end
                ST_GNT_VID: begin
                    if (!i_mem_wait) begin
                        r_vid_data <= i_mem_rdata[VIDEO_DATA_W-1:0];
                        r_owner    <= OWN_VID;
                        r_mem_read <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                ST_GNT_CPU: begin
                    if (!i_mem_wait) begin
                        if (r_mem_read)
                            r_cpu_rdata <= i_mem_rdata;
                        r_owner     <= OWN_CPU;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                // Turnaround cycle: strobes already low, owner sees its wait pulse.
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_vid_wait    = ~((r_state == ST_DONE) && (r_owner == OWN_VID));
    assign o_cpu_wait    = ~((r_state == ST_DONE) && (r_owner == OWN_CPU));
    assign o_vid_data    = r_vid_data;
    assign o_cpu_rdata   = r_cpu_rdata;
    assign o_mem_read    = r_mem_read;
    assign o_mem_write   = r_mem_write;
    assign o_mem_address = r_mem_address;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_be      = r_mem_be;

endmodule

// File: tb/tb_vidmem_arbiter.sv
// Self-checking bench for vidmem_arbiter: directed vector table, hand-written
// corner sequences, then two random masters against a word-level memory model.
module tb_vidmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam logic [31:0] BASE = 32'h00c0_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              vid_read;
    logic [ADDR_W-1:0] vid_address;
    logic              vid_wait;
    logic [23:0]       vid_data;
    logic              cpu_read, cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_wdata;
    logic [BE_W-1:0]   cpu_be;
    logic              cpu_wait;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_wait;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    vidmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_VID_BURST(8)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_vid_read(vid_read), .i_vid_address(vid_address),
        .o_vid_wait(vid_wait), .o_vid_data(vid_data),
        .i_cpu_read(cpu_read), .i_cpu_write(cpu_write), .i_cpu_address(cpu_address),
        .i_cpu_wdata(cpu_wdata), .i_cpu_be(cpu_be),
        .o_cpu_wait(cpu_wait), .o_cpu_rdata(cpu_rdata),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_address(mem_address),
        .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
        .i_mem_wait(mem_wait), .i_mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // dev_mem is the memory behind the bus; ref_mem is what the masters believe it holds.
    logic [31:0] dev_mem [16];
    logic [31:0] ref_mem [16];
    int          wait_cfg  = 0;
    bit          rand_wait = 1'b0;

    // Memory device: stalls for a configured number of cycles per access.
    bit          in_acc = 1'b0;
    int          stall;
    logic [31:0] acc_addr;
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            if (!in_acc) begin
                in_acc   = 1'b1;
                stall    = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
                acc_addr = mem_address;
            end else begin
                chk("addr_stable", mem_address, acc_addr);
            end
            if (stall > 0) begin
                mem_wait = 1'b1;
                stall--;
            end else begin
                mem_wait = 1'b0;
                if (mem_write)
                    dev_mem[mem_address[5:2]] = merge_be(dev_mem[mem_address[5:2]], mem_wdata, mem_be);
                mem_rdata = dev_mem[mem_address[5:2]];
            end
        end else begin
            in_acc    = 1'b0;
            mem_wait  = 1'b1;
            mem_rdata = $urandom;
        end
    end

    typedef struct {
        bit          vid;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          nwait;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] last_vid = '0;
    logic [31:0] last_cpu = '0;

    // Applies one transaction from IDLE; returns with the DUT back in IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int   edges;
        bit   done;
        int   idx;
        logic [1:0] exp_strobe;
        idx        = int'(v.addr[5:2]);
        exp_strobe = v.vid ? 2'b10 : (v.wr ? 2'b01 : 2'b10);
        wait_cfg   = v.nwait;
        if (v.vid) begin
            vid_read = 1'b1; vid_address = v.addr;
        end else begin
            cpu_read = v.rd; cpu_write = v.wr; cpu_address = v.addr;
            cpu_wdata = v.wdata; cpu_be = v.be;
        end
        edges = 0;
        done  = 1'b0;
        while (!done && edges < 50) begin
            @(posedge clk); #1;
            edges++;
            if (v.vid ? !vid_wait : !cpu_wait) done = 1'b1;
            else chk({tag, "_strobe"}, {mem_read, mem_write}, exp_strobe);
            if (edges == 1) begin
                chk({tag, "_addr"}, mem_address, v.addr);
                if (!v.vid && v.wr) chk({tag, "_wd_be"}, {mem_wdata, mem_be}, {v.wdata, v.be});
            end
        end
        chk({tag, "_latency"}, edges, 2 + v.nwait);
        chk({tag, "_turnaround"}, {mem_read, mem_write}, 2'b00);
        chk({tag, "_other_wait"}, v.vid ? cpu_wait : vid_wait, 1'b1);
        if (v.vid) begin
            chk({tag, "_vdata"}, vid_data, v.exp[23:0]);
            last_vid = v.exp;
            chk({tag, "_rdata_hold"}, cpu_rdata, last_cpu);
        end else if (v.wr) begin
            ref_mem[idx] = merge_be(ref_mem[idx], v.wdata, v.be);
            chk({tag, "_memword"}, dev_mem[idx], ref_mem[idx]);
            chk({tag, "_rdata_hold"}, cpu_rdata, last_cpu);
            chk({tag, "_vdata_hold"}, vid_data, last_vid[23:0]);
        end else begin
            chk({tag, "_rdata"}, cpu_rdata, v.exp);
            last_cpu = v.exp;
            chk({tag, "_vdata_hold"}, vid_data, last_vid[23:0]);
        end
        vid_read = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_pulse_width"}, {vid_wait, cpu_wait}, 2'b11);
    endtask

    task automatic vid_master(input int n);
        int idx, e;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            idx = int'($urandom_range(0, 15));
            vid_read = 1'b1; vid_address = BASE + 32'(idx * 4);
            e = 0;
            do begin @(posedge clk); #1; e++; end while (vid_wait && e < 300);
            chk("rnd_vid_timeout", e < 300, 1'b1);
            chk("rnd_vid_data", vid_data, ref_mem[idx][23:0]);
            vid_read = 1'b0;
        end
    endtask

    task automatic cpu_master(input int n);
        int          idx, e;
        bit          wr;
        logic [31:0] wd;
        logic [3:0]  be;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            idx = int'($urandom_range(0, 15));
            wr  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            be  = 4'($urandom_range(1, 15));
            cpu_address = BASE + 32'(idx * 4);
            cpu_read = ~wr; cpu_write = wr; cpu_wdata = wd; cpu_be = be;
            e = 0;
            do begin @(posedge clk); #1; e++; end while (cpu_wait && e < 300);
            chk("rnd_cpu_timeout", e < 300, 1'b1);
            if (wr) ref_mem[idx] = merge_be(ref_mem[idx], wd, be);
            else    chk("rnd_cpu_rdata", cpu_rdata, ref_mem[idx]);
            cpu_read = 1'b0; cpu_write = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int vd, cd, e;
        vec_t v;
        for (int i = 0; i < 16; i++) begin
            dev_mem[i] = 32'h5A5A_0000 | (32'(i) << 8) | 32'(i);
            ref_mem[i] = dev_mem[i];
        end
        vecs[0] = '{vid:1, rd:1, wr:0, addr:BASE + 32'h00, wdata:0, be:0, nwait:0, exp:32'h005A_0000};
        vecs[1] = '{vid:0, rd:0, wr:1, addr:BASE + 32'h10, wdata:32'hdeadbeef, be:4'hf, nwait:3, exp:0};
        vecs[2] = '{vid:0, rd:1, wr:0, addr:BASE + 32'h10, wdata:0, be:4'hf, nwait:1, exp:32'hdeadbeef};
        vecs[3] = '{vid:0, rd:0, wr:1, addr:BASE + 32'h10, wdata:32'h11223344, be:4'b0101, nwait:0, exp:0};
        vecs[4] = '{vid:0, rd:1, wr:0, addr:BASE + 32'h10, wdata:0, be:4'hf, nwait:2, exp:32'hde22be44};
        vecs[5] = '{vid:1, rd:1, wr:0, addr:BASE + 32'h10, wdata:0, be:0, nwait:0, exp:32'h0022_be44};
        vecs[6] = '{vid:0, rd:1, wr:1, addr:BASE + 32'h20, wdata:32'hcafef00d, be:4'hf, nwait:1, exp:0};
        vecs[7] = '{vid:0, rd:1, wr:0, addr:BASE + 32'h20, wdata:0, be:4'hf, nwait:0, exp:32'hcafef00d};
        vecs[8] = '{vid:1, rd:1, wr:0, addr:BASE + 32'h24, wdata:0, be:0, nwait:2, exp:32'h005A_0909};

        rst = 1'b1;
        vid_read = 1'b0; vid_address = '0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_wdata = '0; cpu_be = '0;
        mem_wait = 1'b1; mem_rdata = '0;
        #12;
        chk("reset_waits", {vid_wait, cpu_wait}, 2'b11);
        chk("reset_strobes", {mem_read, mem_write}, 2'b00);
        chk("reset_bus", {mem_address, mem_wdata, mem_be}, '0);
        chk("reset_data", {vid_data, cpu_rdata}, '0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_grant", {mem_read, mem_write}, 2'b00);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests: video first, CPU granted after DONE and IDLE.
        wait_cfg = 0;
        vid_read = 1'b1; vid_address = BASE;
        cpu_read = 1'b1; cpu_address = BASE + 32'h10;
        vd = 0; cd = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk("tie_vid_first", mem_address, BASE);
            if (!vid_wait) begin vd = k; vid_read = 1'b0; end
            if (!cpu_wait) begin cd = k; cpu_read = 1'b0; break; end
            if (vd == 0) chk("tie_cpu_wait_high", cpu_wait, 1'b1);
        end
        chk("tie_vid_done", vd, 2);
        chk("tie_cpu_done", cd, 5);
        chk("tie_cpu_rdata", cpu_rdata, ref_mem[4]);
        @(posedge clk); #1;

        // CPU drops its read mid-grant: access and pulse still happen, no regrant.
        wait_cfg = 2;
        cpu_read = 1'b1; cpu_address = BASE + 32'h20;
        @(posedge clk); #1;
        cpu_read = 1'b0;
        cd = 0;
        for (int k = 2; k <= 8; k++) begin
            @(posedge clk); #1;
            if (!cpu_wait) begin
                if (cd == 0) cd = k;
                else chk("drop_single_pulse", k, cd);
            end
            if (k > 4) chk("drop_no_regrant", {mem_read, mem_write}, 2'b00);
        end
        chk("drop_done_edge", cd, 4);
        chk("drop_rdata", cpu_rdata, ref_mem[8]);
        last_cpu = ref_mem[8];

        // Asynchronous reset in the middle of a stalled video grant.
        wait_cfg = 100;
        vid_read = 1'b1; vid_address = BASE + 32'h04;
        @(posedge clk); #1;
        chk("rst_mid_granted", mem_read, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_strobe", {mem_read, mem_write}, 2'b00);
        chk("rst_mid_wait", vid_wait, 1'b1);
        chk("rst_mid_vdata", vid_data, 24'h0);
        vid_read = 1'b0;
        @(negedge clk) rst = 1'b0;
        last_vid = '0; last_cpu = '0;
        @(posedge clk); #1;
        v = '{vid:1, rd:1, wr:0, addr:BASE + 32'h04, wdata:0, be:0, nwait:0, exp:32'h005A_0101};
        run_vec(v, "post_rst");

        // Random traffic from both masters with random memory stalls.
        rand_wait = 1'b1;
        fork
            vid_master(40);
            cpu_master(40);
        join
        rand_wait = 1'b0;
        wait_cfg  = 0;
        repeat (3) @(posedge clk);
        #1;

`ifdef VIDMEM_ARB_FAIRNESS_EN
        begin
            int seq_n;
            vid_read = 1'b1; vid_address = BASE;
            cpu_read = 1'b1; cpu_address = BASE + 32'h08;
            seq_n = 0;
            e = 0;
            while (seq_n < 18 && e < 400) begin
                @(posedge clk); #1; e++;
                if (!vid_wait || !cpu_wait) begin
                    chk("fair_order", !cpu_wait, (seq_n % 9) == 8);
                    seq_n++;
                end
            end
            chk("fair_count", seq_n, 18);
            vid_read = 1'b0; cpu_read = 1'b0;
            @(posedge clk); #1;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
